// File: rtl/instruction_fetch.sv
// Fetch stage: PC + instruction register feeding decode, with stall hold and execute redirects.
// Optional JMP_EARLY_EN: jmp opcodes redirect the PC at capture time (zero-bubble jmp).
module instruction_fetch #(
  parameter int                 ADDR_W   = 4,
  parameter int                 INST_W   = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter logic [3:0]         OPC_JMP  = 4'b1000
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [INST_W-1:0] rom_instruction,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic [INST_W-1:0] ir,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_valid
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    HOLD  = 2'd2,
    FLUSH = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [INST_W-1:0]   ir_q, ir_d;
  logic [ADDR_W-1:0]   ir_pc_q, ir_pc_d;
  logic                ir_valid_q, ir_valid_d;
  logic                take_redirect;
  logic                capture;
  logic [ADDR_W-1:0]   seq_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT: state_d = RUN;
      RUN, HOLD, FLUSH: begin
        if (redirect_valid) begin
          state_d = FLUSH;
        end else if (stall) begin
          state_d = HOLD;
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // BOOT spends one cycle idle; every other state fetches unless stalled or redirected.
  always_comb begin
    take_redirect = 1'b0;
    capture       = 1'b0;
    if (state_q != BOOT) begin
      take_redirect = redirect_valid;
      capture       = !redirect_valid && !stall;
    end
  end

`ifdef JMP_EARLY_EN
  always_comb begin
    if (rom_instruction[INST_W-1 -: 4] == OPC_JMP) begin
      seq_pc = ADDR_W'(rom_instruction[11:8]);
    end else begin
      seq_pc = pc_q + ADDR_W'(1);
    end
  end
`else
  assign seq_pc = pc_q + ADDR_W'(1);
`endif

  always_comb begin
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    if (take_redirect) begin
      pc_d       = redirect_target;
      ir_valid_d = 1'b0;
    end else if (capture) begin
      pc_d       = seq_pc;
      ir_d       = rom_instruction;
      ir_pc_d    = pc_q;
      ir_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  assign rom_address = pc_q;
  assign ir          = ir_q;
  assign ir_pc       = ir_pc_q;
  assign ir_valid    = ir_valid_q;

endmodule
